// File: rtl/uart_tx_queue.sv
// Transmit FIFO and request sequencer feeding the uart_tx serializer.
// Optional saturating dropped-write counter: define UART_TX_QUEUE_DROP_CNT_EN.
module uart_tx_queue #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_valid,
  input  logic [DATA_BITS-1:0]      wr_data,
  output logic                      wr_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  input  logic                      clr_overflow,
  output logic                      send_request,
  output logic [DATA_BITS-1:0]      tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
`ifdef UART_TX_QUEUE_DROP_CNT_EN
  output logic [7:0]                drop_count,
`endif
  output logic                      queue_idle
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 send_next;
  logic                 pop;
  logic                 wr_en;
  logic                 drop;
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [DATA_BITS-1:0] mem [DEPTH];

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign wr_ready   = (level != LVL_W'(DEPTH));
  assign wr_en      = wr_valid && wr_ready;
  assign drop       = wr_valid && !wr_ready;
  assign queue_idle = (level == '0) && (state == IDLE) && !tx_busy;

  // Controller next-state; the pop happens on the way into REQ.
  always_comb begin
    state_next = state;
    send_next  = send_request;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          send_next  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (tx_busy) begin
          send_next  = 1'b0;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) state_next = IDLE;
      end
      default: begin
        send_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      send_request <= 1'b0;
      tx_data      <= '0;
      overflow     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      send_request <= send_next;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

`ifdef UART_TX_QUEUE_DROP_CNT_EN
  // A drop in the clearing cycle restarts the count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= 8'd0;
    end else if (drop) begin
      if (clr_overflow)              drop_count <= 8'd1;
      else if (drop_count != 8'hFF)  drop_count <= drop_count + 8'd1;
    end else if (clr_overflow) begin
      drop_count <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized bench for uart_tx_queue against a queue-based reference model.
// Build with UART_TX_QUEUE_DROP_CNT_EN to also check drop_count.
module tb_uart_tx_queue;

  logic       clk;
  logic       reset_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [4:0] level;
  logic       overflow;
  logic       clr_overflow;
  logic       send_request;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       queue_idle;
`ifdef UART_TX_QUEUE_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  uart_tx_queue #(.DATA_BITS(8), .DEPTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .send_request (send_request),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
`ifdef UART_TX_QUEUE_DROP_CNT_EN
    .drop_count   (drop_count),
`endif
    .queue_idle   (queue_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: stored words, one outstanding handoff, sticky flags.
  logic [7:0] mq[$];
  logic [7:0] acc[$];
  bit         m_req;
  bit         m_svc;
  bit         m_ovf;
  logic [7:0] m_tx;
  int         m_drop;
  int         n_acc;
  int         n_cap;
  int         ser_busy_cnt;
  int         ser_done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    acc.delete();
    m_req = 1'b0;
    m_svc = 1'b0;
    m_ovf = 1'b0;
    m_tx  = 8'h00;
    m_drop = 0;
    n_acc = 0;
    n_cap = 0;
  endtask

  // One clock edge of the reference, using the inputs present before the edge.
  task automatic model_edge();
    int  sz;
    bit  full, dropped, do_pop, n_req, n_svc;
    sz      = mq.size();
    full    = (sz == 16);
    dropped = wr_valid && full;
    do_pop  = !m_req && !m_svc && (sz != 0);
    n_req   = m_req;
    n_svc   = m_svc;
    if (m_req && tx_busy) begin n_req = 1'b0; n_svc = 1'b1; end
    if (m_svc && tx_done) n_svc = 1'b0;
    if (do_pop) begin
      m_tx  = mq.pop_front();
      n_req = 1'b1;
    end
    if (wr_valid && !full) begin
      mq.push_back(wr_data);
      acc.push_back(wr_data);
      n_acc++;
    end
    m_req = n_req;
    m_svc = n_svc;
    if (dropped)           m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    if (dropped)           m_drop = clr_overflow ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    else if (clr_overflow) m_drop = 0;
  endtask

  task automatic check_outputs();
    check("level", 32'(level), 32'(mq.size()));
    check("wr_ready", 32'(wr_ready), 32'(mq.size() != 16));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("send_request", 32'(send_request), 32'(m_req));
    check("tx_data", 32'(tx_data), 32'(m_tx));
    check("queue_idle", 32'(queue_idle),
          32'((mq.size() == 0) && !m_req && !m_svc && !tx_busy));
`ifdef UART_TX_QUEUE_DROP_CNT_EN
    check("drop_count", 32'(drop_count), 32'(m_drop));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset applied away from any clock edge; the serializer resets too.
  task automatic do_reset();
    reset_n      = 1'b0;
    wr_valid     = 1'b0;
    clr_overflow = 1'b0;
    tx_busy      = 1'b0;
    tx_done      = 1'b0;
    ser_busy_cnt = 0;
    ser_done_cnt = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Serializer stand-in: accepts a request in its idle phase, even while tx_done is high.
  task automatic ser_tick(input int accept_pct);
    logic [7:0] exp;
    if (tx_busy) begin
      ser_busy_cnt--;
      if (ser_busy_cnt <= 0) begin
        tx_busy      = 1'b0;
        tx_done      = 1'b1;
        ser_done_cnt = int'($urandom_range(1, 3));
      end
    end else if (send_request && ($urandom_range(0, 99) < accept_pct)) begin
      tx_busy      = 1'b1;
      tx_done      = 1'b0;
      ser_busy_cnt = int'($urandom_range(1, 4));
      n_cap++;
      check("sb_pending", 32'(acc.size() != 0), 32'd1);
      if (acc.size() != 0) begin
        exp = acc.pop_front();
        check("sb_byte", 32'(tx_data), 32'(exp));
      end
    end else if (ser_done_cnt > 0) begin
      ser_done_cnt--;
      if (ser_done_cnt == 0) tx_done = 1'b0;
    end
  endtask

  task automatic drain(input int accept_pct);
    bit done;
    done = 1'b0;
    wr_valid     = 1'b0;
    clr_overflow = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      step();
      ser_tick(accept_pct);
      done = (mq.size() == 0) && !m_req && !m_svc && !tx_busy;
    end
    check("drain_done", 32'(done), 32'd1);
    check("captured", 32'(n_cap), 32'(n_acc));
    tx_done      = 1'b0;
    ser_done_cnt = 0;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b1;
    wr_valid     = 1'b0;
    wr_data      = 8'h00;
    clr_overflow = 1'b0;
    tx_busy      = 1'b0;
    tx_done      = 1'b0;
    #2;
    do_reset();

    // Single word through the full handshake.
    write_word(8'hA5);
    step();
    step();
    tx_busy = 1'b1;
    step();
    step();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    step();

    // Fill past full with the serializer stalled.
    for (int i = 0; i < 18; i++) write_word(8'(i));
    step();

    // Full queue with a write in the popping cycle, then clear overflow.
    tx_busy = 1'b1;
    step();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    step();
    wr_valid     = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    step();

    // Stream 40 bytes through a serializer model across pointer wrap.
    do_reset();
    for (int c = 0; c < 4000 && n_acc < 40; c++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_data  = 8'($urandom);
      step();
      ser_tick(70);
    end
    check("stream_fill", 32'(n_acc), 32'd40);
    drain(70);

    // Heavy writes against a slow serializer with occasional clears.
    for (int c = 0; c < 300; c++) begin
      wr_valid     = ($urandom_range(0, 99) < 85);
      wr_data      = 8'($urandom);
      clr_overflow = ($urandom_range(0, 15) == 0);
      step();
      ser_tick(40);
    end
    drain(40);

    // Reset while waiting for tx_done with five words queued.
    for (int i = 0; i < 6; i++) write_word(8'(8'hC0 + i));
    step();
    tx_busy = 1'b1;
    step();
    check("pre_rst_level", 32'(level), 32'd5);
    #2;
    do_reset();

    // Saturate the drop counter after releasing clr_overflow.
    for (int i = 0; i < 17; i++) write_word(8'(i));
    clr_overflow = 1'b1;
    step();
    step();
    clr_overflow = 1'b0;
    wr_valid     = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr_data = 8'($urandom);
      step();
    end
    wr_valid     = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Transmit-side buffer and sequencer that sits directly upstream of the uart_tx serializer.
- Accepts bytes from a host write port into a DEPTH-entry circular FIFO.
- Hands one word at a time to the serializer using its send_request / tx_busy / tx_done handshake.
- Lets software burst-write a message without polling the serializer per byte.

Parameters:
- DATA_BITS, 8, word width; must match the serializer's DATA_BITS.
- DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- wr_valid  input  1  host write strobe, one word per clk cycle.
- wr_data  input  DATA_BITS  host write word.
- wr_ready  output  1  high when the FIFO is not full.
- level  output  $clog2(DEPTH)+1  number of words currently stored.
- overflow  output  1  sticky flag: a write was dropped.
- clr_overflow  input  1  synchronous clear of overflow.
- send_request  output  1  to the serializer; held high until it accepts.
- tx_data  output  DATA_BITS  to the serializer; registered; stable while send_request is high.
- tx_busy  input  1  from the serializer.
- tx_done  input  1  from the serializer; held high for one baud period after the stop bit.
- queue_idle  output  1  FIFO empty, controller in IDLE, and tx_busy low.

Behaviour:
- Reset (reset_n low, asynchronous assert, release on a clk edge):
  - rd_ptr = wr_ptr = 0, level = 0.
  - send_request = 0, tx_data = 0, overflow = 0.
  - State = IDLE, wr_ready = 1, queue_idle = 1 (once tx_busy is low).
  - FIFO storage is not reset.
- Reset mid-transfer: a queued or in-flight word is discarded. The serializer is reset from the same source.
- Write port:
  - wr_valid && wr_ready: store wr_data at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - wr_valid && !wr_ready: the word is dropped and overflow is set on the next edge.
  - wr_ready = (level != DEPTH), computed from registered level. While full, a pop in the same cycle does not admit a write.
- overflow: set wins over clr_overflow in the same cycle.
- level: +1 on accepted write, -1 on pop, unchanged when both occur. Never exceeds DEPTH, never goes below 0.
- Controller FSM, states IDLE, REQ, WAIT_DONE:
  - IDLE: if level != 0, load tx_data <= mem[rd_ptr], pop (rd_ptr wraps, level decrements), set send_request = 1, go to REQ. Otherwise stay in IDLE.
  - REQ: hold send_request and tx_data. When tx_busy == 1, clear send_request and go to WAIT_DONE. No timeout.
  - WAIT_DONE: when tx_done == 1, go to IDLE.
  - Unreachable states recover to IDLE with send_request = 0.
- Back-to-back words: the next word may be requested while tx_done is still high, because the serializer accepts a request in its IDLE state. REQ waits on tx_busy rather than on a tick, so there is no double issue.
- Latency:
  - Write into an empty queue with the controller in IDLE: send_request rises 2 clk after the write edge (write lands, then IDLE pops).
  - Pop happens on REQ entry, so level counts only words not yet handed off.
- queue_idle is combinational from registered state, level and tx_busy.

Optional Feature:
- Macro: UART_TX_QUEUE_DROP_CNT_EN.
- When defined:
  - Adds output drop_count, 8 bits.
  - Increments on every dropped write and saturates at 255.
  - Reset to 0; cleared by clr_overflow in the same cycle as overflow.
  - A drop coincident with clear yields drop_count = 1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then write 0xA5: next cycle level = 1; one cycle later send_request = 1, tx_data = 0xA5, level = 0. Model tx_busy high after 3 clk: send_request falls on the following edge. Pulse tx_done: state returns to IDLE and queue_idle = 1 once tx_busy drops.
- Write 16 words 0x00..0x0F with tx_busy held low: the first is popped into REQ and level settles at 15. Write 2 more: the first is accepted (level 16, wr_ready = 0), the second is dropped and overflow = 1. With the macro, drop_count = 1.
- Full queue plus write in the same cycle as a pop: the write is rejected and level goes 16 -> 15. Then clr_overflow: overflow = 0 and drop_count = 0.
- Stream 40 bytes with a serializer model: bytes emerge in order across pointer wrap (rd_ptr passes 15 -> 0 twice). There are no gaps beyond one IDLE cycle, and no word is issued twice when tx_done is high on REQ re-entry.
- Assert reset_n low while in WAIT_DONE with level = 5: send_request = 0, level = 0, overflow = 0 immediately, with no clk edge needed.
- Hold clr_overflow and drop 300 writes (macro on) with clr_overflow released first: drop_count saturates at 255 and overflow stays 1.
